// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch controller: FSM encoding, reset PC, halt word.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // Boot address of the program image.
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    // SYSCALL encoding; consuming it stops fetch for good.
    localparam logic [31:0] DEF_HALT_WORD = 32'h0000_000C;
    // Byte stride between sequential instructions.
    localparam logic [31:0] INSTR_BYTES   = 32'd4;

    // Sign-extended, word-scaled branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_next_calc.sv
// Next-PC selection for the instruction currently held for decode.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is used.
module pc_next_calc
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    output logic [31:0] pc4,
    output logic [31:0] next_pc
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign pc4           = pc + INSTR_BYTES;
    assign branch_target = pc4 + branch_offset(imm16);
    assign jump_target   = {pc[31:28], imm26, 2'b00};

    // Taken branch beats jump; a not-taken branch always falls through.
    always_comb begin
        next_pc = pc4;
        if (branch) begin
            if (zero) begin
                next_pc = branch_target;
            end
        end else if (jump) begin
            next_pc = jump_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter owner: fetches one word via req/ack, holds it for decode, then advances PC.
// Latency: ack -> instr_valid 1 cycle; zero-wait memory yields one instruction every 2 cycles.
// Backpressure: stall freezes the held word and PC indefinitely; memory stalls by delaying ack.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    output logic [31:0] pc,
    output logic        halted
);

    fetch_state_t state;
    logic [31:0]  pc4;
    logic [31:0]  next_pc;

    pc_next_calc u_next (
        .pc      (pc),
        .branch  (branch),
        .zero    (zero),
        .jump    (jump),
        .imm16   (imm16),
        .imm26   (imm26),
        .pc4     (pc4),
        .next_pc (next_pc)
    );

    // The fetch address is the PC register itself, so it is stable for the whole request.
    assign imem_addr = pc;

    // Fetch sequencer: state, PC, held instruction and all handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= {RESET_PC[31:2], 2'b00};
            imem_req    <= 1'b0;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end
                ST_FETCH: begin
                    // stall has no meaning until a word is held.
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        if (instr == HALT_WORD) begin
                            // PC points past the SYSCALL; control inputs are ignored.
                            pc     <= pc4;
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] pc;
    logic        halted;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .imm16       (imm16),
        .imm26       (imm26),
        .pc          (pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on every accepted fetch and every newly presented word.
    logic ack_prev   = 1'b0;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (imem_req && imem_ack) begin
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
            end else begin
                chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
            end
        end
        if (instr_valid && !valid_prev) begin
            chk("ack_to_valid_latency", {31'b0, ack_prev}, 32'd1);
            if (exp_instr_q.size() == 0) begin
                chk("unexpected_instr", instr, 32'hxxxx_xxxx);
            end else begin
                chk("instr_word", instr, exp_instr_q.pop_front());
            end
        end
        ack_prev   = imem_req && imem_ack && rst_n;
        valid_prev = instr_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: wait for req, hold ack low for 'delay' cycles, then return one word.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int delay);
        int n = 0;
        while (!imem_req && n < 40) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            chk("req_timeout", {31'b0, imem_req}, 32'd1);
            return;
        end
        for (int k = 0; k < delay; k++) begin
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, a);
            tick();
        end
        exp_addr_q.push_back(a);
        exp_instr_q.push_back(d);
        imem_ack   = 1'b1;
        imem_rdata = d;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    // Decode model: stall for stall_cyc cycles, then consume with the given control inputs.
    task automatic consume(input logic br, input logic z, input logic j,
                           input logic [15:0] i16, input logic [25:0] i26, input int stall_cyc);
        logic [31:0] pc_hold;
        logic [31:0] instr_hold;
        pc_hold    = pc;
        instr_hold = instr;
        for (int k = 0; k < stall_cyc; k++) begin
            tick();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_no_req", {31'b0, imem_req}, 32'd0);
            chk("stall_pc", pc, pc_hold);
            chk("stall_instr", instr, instr_hold);
        end
        stall  = 1'b0;
        branch = br;
        zero   = z;
        jump   = j;
        imm16  = i16;
        imm26  = i26;
        tick();
        stall  = 1'b1;
        branch = 1'b0;
        zero   = 1'b0;
        jump   = 1'b0;
        imm16  = 16'h0;
        imm26  = 26'h0;
    endtask

    task automatic seq_fetch(input logic [31:0] a, input int count);
        for (int k = 0; k < count; k++) begin
            do_fetch(a + 32'(4 * k), 32'h2000_0000 + a + 32'(4 * k), 0);
            consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b1;
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 1'b0;
        imm16      = 16'h0;
        imm26      = 26'h0;

        // Reset state
        repeat (3) tick();
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        rst_n = 1'b1;
        chk("idle_no_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0000_3000);

        // Sequential fetch with ack delays 0 and 3
        do_fetch(32'h3000, 32'h2000_3000, 0);
        consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0);
        do_fetch(32'h3004, 32'h2000_3004, 3);
        consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0);
        seq_fetch(32'h3008, 2);

        // Taken backward branch from 3010 -> 3004
        do_fetch(32'h3010, 32'h1000_FFFC, 0);
        consume(1'b1, 1'b1, 1'b0, 16'hFFFC, 26'h0, 0);
        seq_fetch(32'h3004, 3);

        // Not-taken branch with jump also set falls through to 3014
        do_fetch(32'h3010, 32'h1000_FFFC, 0);
        consume(1'b1, 1'b0, 1'b1, 16'hFFFC, 26'h000_0C40, 0);
        seq_fetch(32'h3014, 3);

        // Jump from 3020 -> 3100
        do_fetch(32'h3020, 32'h0800_0C40, 1);
        consume(1'b0, 1'b0, 1'b1, 16'h0, 26'h000_0C40, 0);

        // Branch and jump both set: branch target 3104+0x10 wins
        do_fetch(32'h3100, 32'h1000_0004, 0);
        consume(1'b1, 1'b1, 1'b1, 16'h0004, 26'h000_0C40, 0);

        // Four stall cycles in HOLD, then sequential
        do_fetch(32'h3114, 32'h2000_3114, 0);
        consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 4);

        // SYSCALL halts fetch; control inputs set to prove they are ignored
        do_fetch(32'h3118, 32'h0000_000C, 2);
        consume(1'b0, 1'b0, 1'b1, 16'h0, 26'h000_0C40, 0);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_pc", pc, 32'h0000_311C);
        chk("halt_valid", {31'b0, instr_valid}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            stall = k[0];
            tick();
            chk("halt_no_req", {31'b0, imem_req}, 32'd0);
        end
        chk("halt_sticky", {31'b0, halted}, 32'd1);
        stall = 1'b1;

        // Reset pulse leaves HALT
        rst_n = 1'b0;
        #1;
        chk("halt_rst_halted", {31'b0, halted}, 32'd0);
        chk("halt_rst_pc", pc, 32'h0000_3000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        tick();
        tick();

        // Reset mid-FETCH with a simultaneous ack: req drops immediately, ack discarded
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        rst_n      = 1'b0;
        #1;
        chk("midfetch_req_drop", {31'b0, imem_req}, 32'd0);
        chk("midfetch_pc", pc, 32'h0000_3000);
        tick();
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        chk("midfetch_valid", {31'b0, instr_valid}, 32'd0);
        chk("midfetch_instr", instr, 32'h0);

        do_fetch(32'h3000, 32'h2000_3000, 0);
        consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0);
        do_fetch(32'h3004, 32'h2000_3004, 0);
        consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0);
        tick();
        tick();

        chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("instr_queue_drained", 32'(exp_instr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
